prog_loader: RTL and testbench

- Synthesizable program loader that sits between an external word stream (bench, UART bridge or debug port) and the core's instruction and data memories.
- Streams instruction words, then optionally data words, into the memories with auto-incrementing addresses.
- Each segment is terminated by an end-marker word. After loading, it raises the core start signal.
- Parametrised successor of the fixed-width, instruction-only load-then-start sequence, adding data loading, addressing, depth/overflow checking, abort and start modes.

---
 rtl/prog_loader_pkg.sv | 16 +
 rtl/loader_seg_writer.sv | 69 ++++++
 rtl/prog_loader.sv | 129 ++++++++++++
 tb/tb_prog_loader.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/prog_loader_pkg.sv
// Shared definitions for the program loader, its segment writers and anything
// that needs to decode loader state or the default end marker.
package prog_loader_pkg;

  localparam int          cXLEN             = 32;
  localparam logic [31:0] cEndMarkerDefault = 32'hDEADBEAF;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    LOAD_INST = 3'd1,
    LOAD_DATA = 3'd2,
    DONE      = 3'd3,
    ERROR     = 3'd4
  } tLoaderState;

endpackage

// File: rtl/loader_seg_writer.sv
// One memory segment: word counter, overflow detection and a registered
// write port whose address is the count at the time the word was accepted.
module loader_seg_writer
  import prog_loader_pkg::*;
#(
  parameter int pDepth = 1024,
  parameter int pXLEN  = cXLEN,
  localparam int cAw   = $clog2(pDepth),
  localparam int cCw   = cAw + 1
) (
  input  logic             iClk,
  input  logic             iRst,
  input  logic             iClear,
  input  logic             iWrReq,
  input  logic [pXLEN-1:0] iWord,
  output logic             oWen,
  output logic [cAw-1:0]   oAddr,
  output logic [pXLEN-1:0] oWData,
  output logic [cCw-1:0]   oCount,
  output logic             oOverflow
);

  logic             wen_q, wen_d;
  logic [cAw-1:0]   addr_q, addr_d;
  logic [pXLEN-1:0] wdata_q, wdata_d;
  logic [cCw-1:0]   count_q, count_d;
  logic             full;

  always_comb begin
    // NOTE: every output of this block gets a default first so no path leaves one unassigned and no latch is inferred.
    full    = (count_q == cCw'(pDepth));
    wen_d   = iWrReq && !full;
    count_d = count_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    if (iClear) begin
      count_d = '0;
    end else if (wen_d) begin
      count_d = count_q + cCw'(1);
    end
    if (wen_d) begin
      addr_d  = count_q[cAw-1:0];
      wdata_d = iWord;
    end
  end

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      wen_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      count_q <= '0;
    end else begin
      // NOTE: non-blocking so every flop updates from the values present before the edge.
      wen_q   <= wen_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      count_q <= count_d;
    end
  end

  // A full segment refuses the word; the parent turns this into ERROR.
  assign oOverflow = iWrReq && full;
  assign oWen      = wen_q;
  assign oAddr     = addr_q;
  assign oWData    = wdata_q;
  assign oCount    = count_q;

endmodule

// File: rtl/prog_loader.sv
// Streams instruction words, then optionally data words, into the core memories
// and releases the core once every segment has seen its end marker.
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int          pXLEN       = cXLEN,
  parameter int          pInstDepth  = 1024,
  parameter int          pDataDepth  = 1024,
  parameter logic [31:0] pEndMarker  = cEndMarkerDefault,
  parameter bit          pLoadData   = 1'b1,
  parameter bit          pStartPulse = 1'b0,
  localparam int cInstAw = $clog2(pInstDepth),
  localparam int cDataAw = $clog2(pDataDepth)
) (
  input  logic               iClk,
  input  logic               iRst,
  input  logic               iLoadReq,
  input  logic               iAbort,
  input  logic               iValid,
  output logic               oReady,
  input  logic [pXLEN-1:0]   iWord,
  output logic               oInstWen,
  output logic [cInstAw-1:0] oInstAddr,
  output logic [pXLEN-1:0]   oInst2Write,
  output logic               oDataWen,
  output logic [cDataAw-1:0] oDataAddr,
  output logic [pXLEN-1:0]   oData2Write,
  output logic               oStart,
  output logic               oBusy,
  output logic               oError,
  output logic [cInstAw:0]   oInstCount,
  output logic [cDataAw:0]   oDataCount
);

  localparam logic [2:0]       ST_IDLE      = IDLE;
  localparam logic [2:0]       ST_LOAD_INST = LOAD_INST;
  localparam logic [2:0]       ST_LOAD_DATA = LOAD_DATA;
  localparam logic [2:0]       ST_DONE      = DONE;
  localparam logic [2:0]       ST_ERROR     = ERROR;
  localparam logic [pXLEN-1:0] cMarker      = pXLEN'(pEndMarker);

  logic [2:0] state_q, state_d;
  logic       active_q, active_d;
  logic       start_q, start_d;
  logic       error_q, error_d;
  logic       accept, is_marker, inst_wr, data_wr, clr_counts;
  logic       inst_ovf, data_ovf;

  always_comb begin
    // A word arriving together with iAbort is dropped.
    accept     = iValid && active_q && !iAbort;
    is_marker  = (iWord == cMarker);
    inst_wr    = accept && !is_marker && (state_q == ST_LOAD_INST);
    data_wr    = accept && !is_marker && (state_q == ST_LOAD_DATA);
    clr_counts = 1'b0;
    state_d    = state_q;
    if (iAbort) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE, ST_ERROR: begin
          if (iLoadReq) begin
            state_d    = ST_LOAD_INST;
            clr_counts = 1'b1;
          end
        end
        ST_LOAD_INST: begin
          if (accept && is_marker) state_d = pLoadData ? ST_LOAD_DATA : ST_DONE;
          else if (inst_ovf)       state_d = ST_ERROR;
        end
        ST_LOAD_DATA: begin
          if (accept && is_marker) state_d = ST_DONE;
          else if (data_ovf)       state_d = ST_ERROR;
        end
        default: state_d = ST_IDLE;
      endcase
    end
    // Status outputs are registered copies of the next state.
    active_d = (state_d == ST_LOAD_INST) || (state_d == ST_LOAD_DATA);
    error_d  = (state_d == ST_ERROR);
    start_d  = (state_d == ST_DONE) && (!pStartPulse || (state_q != ST_DONE));
  end

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      state_q  <= ST_IDLE;
      active_q <= 1'b0;
      start_q  <= 1'b0;
      error_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      active_q <= active_d;
      start_q  <= start_d;
      error_q  <= error_d;
    end
  end

  loader_seg_writer #(.pDepth(pInstDepth), .pXLEN(pXLEN)) u_inst_writer (
    .iClk      (iClk),
    .iRst      (iRst),
    .iClear    (clr_counts),
    .iWrReq    (inst_wr),
    .iWord     (iWord),
    .oWen      (oInstWen),
    .oAddr     (oInstAddr),
    .oWData    (oInst2Write),
    .oCount    (oInstCount),
    .oOverflow (inst_ovf)
  );

  loader_seg_writer #(.pDepth(pDataDepth), .pXLEN(pXLEN)) u_data_writer (
    .iClk      (iClk),
    .iRst      (iRst),
    .iClear    (clr_counts),
    .iWrReq    (data_wr),
    .iWord     (iWord),
    .oWen      (oDataWen),
    .oAddr     (oDataAddr),
    .oWData    (oData2Write),
    .oCount    (oDataCount),
    .oOverflow (data_ovf)
  );

  assign oReady = active_q;
  assign oBusy  = active_q;
  assign oStart = start_q;
  assign oError = error_q;

endmodule

// File: tb/tb_prog_loader.sv
// Bench for prog_loader: a 4-deep instruction+data loader with level start and an
// 8-deep instruction-only loader with pulsed start, checked against a segment model.
module tb_prog_loader;
  import prog_loader_pkg::*;

  localparam logic [31:0] MK = cEndMarkerDefault;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // Loader A: 4-word segments, data segment, level start
  logic        a_load, a_abort, a_valid, a_ready;
  logic [31:0] a_word, a_idata, a_ddata;
  logic        a_iwen, a_dwen, a_start, a_busy, a_error;
  logic [1:0]  a_iaddr, a_daddr;
  logic [2:0]  a_icnt, a_dcnt;

  // Loader B: 8-word instruction segment only, pulsed start
  logic        b_load, b_abort, b_valid, b_ready;
  logic [31:0] b_word, b_idata, b_ddata;
  logic        b_iwen, b_dwen, b_start, b_busy, b_error;
  logic [2:0]  b_iaddr;
  logic [1:0]  b_daddr;
  logic [3:0]  b_icnt;
  logic [2:0]  b_dcnt;

  prog_loader #(.pXLEN(32), .pInstDepth(4), .pDataDepth(4), .pEndMarker(MK),
                .pLoadData(1'b1), .pStartPulse(1'b0)) dut_a (
    .iClk(clk), .iRst(rst), .iLoadReq(a_load), .iAbort(a_abort), .iValid(a_valid),
    .oReady(a_ready), .iWord(a_word), .oInstWen(a_iwen), .oInstAddr(a_iaddr),
    .oInst2Write(a_idata), .oDataWen(a_dwen), .oDataAddr(a_daddr), .oData2Write(a_ddata),
    .oStart(a_start), .oBusy(a_busy), .oError(a_error), .oInstCount(a_icnt), .oDataCount(a_dcnt)
  );

  prog_loader #(.pXLEN(32), .pInstDepth(8), .pDataDepth(4), .pEndMarker(MK),
                .pLoadData(1'b0), .pStartPulse(1'b1)) dut_b (
    .iClk(clk), .iRst(rst), .iLoadReq(b_load), .iAbort(b_abort), .iValid(b_valid),
    .oReady(b_ready), .iWord(b_word), .oInstWen(b_iwen), .oInstAddr(b_iaddr),
    .oInst2Write(b_idata), .oDataWen(b_dwen), .oDataAddr(b_daddr), .oData2Write(b_ddata),
    .oStart(b_start), .oBusy(b_busy), .oError(b_error), .oInstCount(b_icnt), .oDataCount(b_dcnt)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Write monitors: one entry per cycle with a write enable high
  logic [1:0]  ia_q[$], da_q[$];
  logic [31:0] id_q[$], dd_q[$];
  int          b_wen_n = 0;
  int          b_start_n = 0;

  always @(negedge clk) begin
    if (a_iwen) begin ia_q.push_back(a_iaddr); id_q.push_back(a_idata); end
    if (a_dwen) begin da_q.push_back(a_daddr); dd_q.push_back(a_ddata); end
    if (b_iwen) b_wen_n++;
    if (b_start) b_start_n++;
  end

  logic [31:0] stim_q[$];
  int          gap_q[$];
  logic [31:0] m_inst[$], m_data[$];

  // Present each word of stim_q, with gap_q[i] idle cycles first; gives up on a word after 8 stalled cycles
  task automatic stream_a(output int n_acc);
    n_acc = 0;
    for (int i = 0; i < stim_q.size(); i++) begin
      int g;
      int w8;
      g = (i < gap_q.size()) ? gap_q[i] : 0;
      repeat (g) begin @(negedge clk); a_valid = 1'b0; end
      @(negedge clk); a_valid = 1'b1; a_word = stim_q[i];
      w8 = 0;
      while (!a_ready && w8 < 8) begin @(negedge clk); w8++; end
      if (!a_ready) break;
      @(posedge clk); n_acc++;
    end
    @(negedge clk); a_valid = 1'b0;
  endtask

  // Full load on A of m_inst then m_data, predicted from segment rules alone
  task automatic run_and_check_a(input string tag);
    int ni, nd, exp_acc, exp_ic, exp_dc, n_acc, ib, db;
    bit exp_err;
    ni = m_inst.size();
    nd = m_data.size();
    stim_q = {};
    foreach (m_inst[k]) stim_q.push_back(m_inst[k]);
    stim_q.push_back(MK);
    foreach (m_data[k]) stim_q.push_back(m_data[k]);
    stim_q.push_back(MK);
    if (ni > 4)      begin exp_acc = 5;           exp_err = 1'b1; exp_ic = 4;  exp_dc = 0;  end
    else if (nd > 4) begin exp_acc = ni + 6;      exp_err = 1'b1; exp_ic = ni; exp_dc = 4;  end
    else             begin exp_acc = ni + nd + 2; exp_err = 1'b0; exp_ic = ni; exp_dc = nd; end
    ib = ia_q.size();
    db = da_q.size();

    @(negedge clk); a_load = 1'b1;
    @(negedge clk); a_load = 1'b0;
    n_checks++;
    if ({a_ready, a_busy, a_start, a_error, a_icnt, a_dcnt} !== {1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 3'd0})
      $display("FAIL %s_load: rdy/busy/start/err/icnt/dcnt got %b/%b/%b/%b/%0d/%0d expected 1/1/0/0/0/0",
               tag, a_ready, a_busy, a_start, a_error, a_icnt, a_dcnt);
    else n_pass++;

    stream_a(n_acc);
    n_checks++;
    if (n_acc !== exp_acc) $display("FAIL %s_accepted: got %0d expected %0d", tag, n_acc, exp_acc);
    else n_pass++;
    // Sampled in the first cycle after the final acceptance
    n_checks++;
    if ({a_start, a_error, a_ready, a_busy} !== {!exp_err, exp_err, 1'b0, 1'b0})
      $display("FAIL %s_end_state: start/err/rdy/busy got %b/%b/%b/%b expected %b/%b/0/0",
               tag, a_start, a_error, a_ready, a_busy, !exp_err, exp_err);
    else n_pass++;

    repeat (3) @(negedge clk);
    n_checks++;
    if (ia_q.size() - ib !== exp_ic || da_q.size() - db !== exp_dc)
      $display("FAIL %s_wr_count: inst/data writes got %0d/%0d expected %0d/%0d",
               tag, ia_q.size() - ib, da_q.size() - db, exp_ic, exp_dc);
    else n_pass++;
    for (int k = 0; k < exp_ic && ib + k < ia_q.size(); k++) begin
      n_checks++;
      if (ia_q[ib+k] !== 2'(k) || id_q[ib+k] !== m_inst[k])
        $display("FAIL %s_inst_wr%0d: got @%0d=%h expected @%0d=%h", tag, k, ia_q[ib+k], id_q[ib+k], k, m_inst[k]);
      else n_pass++;
    end
    for (int k = 0; k < exp_dc && db + k < da_q.size(); k++) begin
      n_checks++;
      if (da_q[db+k] !== 2'(k) || dd_q[db+k] !== m_data[k])
        $display("FAIL %s_data_wr%0d: got @%0d=%h expected @%0d=%h", tag, k, da_q[db+k], dd_q[db+k], k, m_data[k]);
      else n_pass++;
    end
    n_checks++;
    if (a_icnt !== 3'(exp_ic) || a_dcnt !== 3'(exp_dc) || a_start !== !exp_err || a_error !== exp_err)
      $display("FAIL %s_final: icnt/dcnt/start/err got %0d/%0d/%b/%b expected %0d/%0d/%b/%b",
               tag, a_icnt, a_dcnt, a_start, a_error, exp_ic, exp_dc, !exp_err, exp_err);
    else n_pass++;
  endtask

  function automatic logic [31:0] rand_word();
    logic [31:0] w;
    w = $urandom;
    return (w == MK) ? 32'h0 : w;
  endfunction

  task automatic test_reset;
    rst = 1'b1;
    {a_load, a_abort, a_valid, b_load, b_abort, b_valid} = '0;
    a_word = '0;
    b_word = '0;
    #2;
    n_checks++;
    if ({a_ready, a_busy, a_start, a_error, a_iwen, a_dwen, a_iaddr, a_daddr, a_idata, a_ddata, a_icnt, a_dcnt} !== '0)
      $display("FAIL reset_a: outputs got nonzero (rdy %b busy %b start %b icnt %0d) expected all 0",
               a_ready, a_busy, a_start, a_icnt);
    else n_pass++;
    n_checks++;
    if ({b_ready, b_busy, b_start, b_error, b_iwen, b_dwen, b_iaddr, b_daddr, b_idata, b_ddata, b_icnt, b_dcnt} !== '0)
      $display("FAIL reset_b: outputs got nonzero (rdy %b busy %b start %b icnt %0d) expected all 0",
               b_ready, b_busy, b_start, b_icnt);
    else n_pass++;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_basic_load;
    m_inst = {32'h00000013, 32'h00100093, 32'h00208113};
    m_data = {32'h11, 32'h22};
    gap_q = {};
    run_and_check_a("basic");
  endtask

  task automatic test_overflow;
    gap_q = {};
    m_inst = {rand_word(), rand_word(), rand_word(), rand_word()};
    m_data = {};
    run_and_check_a("inst_full");
    m_inst = {rand_word(), rand_word(), rand_word(), rand_word(), rand_word()};
    run_and_check_a("inst_ovf");
    m_inst = {rand_word()};
    m_data = {rand_word(), rand_word(), rand_word(), rand_word(), rand_word()};
    run_and_check_a("data_ovf");
  endtask

  task automatic test_marker_first;
    gap_q = {};
    m_inst = {};
    m_data = {};
    run_and_check_a("empty_a");
    for (int r = 1; r <= 2; r++) begin
      @(negedge clk); b_load = 1'b1;
      @(negedge clk); b_load = 1'b0; b_valid = 1'b1; b_word = MK;
      n_checks++;
      if (b_ready !== 1'b1) $display("FAIL b_ready_%0d: got %b expected 1", r, b_ready);
      else n_pass++;
      @(negedge clk); b_valid = 1'b0;
      n_checks++;
      if (b_start !== 1'b1 || b_icnt !== 4'd0 || b_busy !== 1'b0)
        $display("FAIL b_done_%0d: start/icnt/busy got %b/%0d/%b expected 1/0/0", r, b_start, b_icnt, b_busy);
      else n_pass++;
      @(negedge clk);
      n_checks++;
      if (b_start !== 1'b0) $display("FAIL b_pulse_%0d: start got %b expected 0", r, b_start);
      else n_pass++;
      repeat (3) @(negedge clk);
      n_checks++;
      if (b_start_n !== r || b_wen_n !== 0)
        $display("FAIL b_counts_%0d: start cycles/wen pulses got %0d/%0d expected %0d/0", r, b_start_n, b_wen_n, r);
      else n_pass++;
    end
  endtask

  task automatic test_gapped;
    m_inst = {rand_word(), rand_word(), rand_word()};
    m_data = {};
    gap_q = {0, 2, 0, 0, 0};
    run_and_check_a("gapped");
  endtask

  task automatic test_abort;
    int n, ib;
    gap_q = {};
    m_inst = {32'h0A0A_0001};
    m_data = {32'h0D0D_0001};
    run_and_check_a("abort_pre");
    @(negedge clk); a_abort = 1'b1;
    @(negedge clk); a_abort = 1'b0;
    n_checks++;
    if ({a_start, a_error, a_busy, a_ready} !== 4'b0 || a_icnt !== 3'd1 || a_dcnt !== 3'd1)
      $display("FAIL abort_done: start/err/busy/rdy/icnt/dcnt got %b/%b/%b/%b/%0d/%0d expected 0/0/0/0/1/1",
               a_start, a_error, a_busy, a_ready, a_icnt, a_dcnt);
    else n_pass++;

    ib = ia_q.size();
    @(negedge clk); a_load = 1'b1;
    @(negedge clk); a_load = 1'b0;
    stim_q = {32'hA1, 32'hA2};
    stream_a(n);
    a_valid = 1'b1; a_word = 32'hA3; a_abort = 1'b1;
    @(negedge clk); a_abort = 1'b0; a_valid = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if (ia_q.size() - ib !== 2 || a_icnt !== 3'd2)
      $display("FAIL abort_drop: writes/icnt got %0d/%0d expected 2/2", ia_q.size() - ib, a_icnt);
    else n_pass++;
    n_checks++;
    if ({a_start, a_error, a_busy, a_ready} !== 4'b0)
      $display("FAIL abort_idle: start/err/busy/rdy got %b/%b/%b/%b expected 0/0/0/0",
               a_start, a_error, a_busy, a_ready);
    else n_pass++;
  endtask

  task automatic test_random;
    for (int it = 0; it < 8; it++) begin
      int ni, nd;
      ni = $urandom_range(5, 0);
      nd = $urandom_range(5, 0);
      m_inst = {};
      m_data = {};
      gap_q = {};
      repeat (ni) m_inst.push_back(rand_word());
      repeat (nd) m_data.push_back(rand_word());
      repeat (ni + nd + 2) gap_q.push_back($urandom_range(2, 0));
      run_and_check_a($sformatf("rand%0d", it));
    end
  endtask

  task automatic test_async_reset;
    int n, ib;
    @(negedge clk); a_load = 1'b1;
    @(negedge clk); a_load = 1'b0;
    gap_q = {};
    stim_q = {32'hC0DE_0001, MK, 32'hDA7A_0001};
    stream_a(n);
    n_checks++;
    if (a_busy !== 1'b1 || a_dwen !== 1'b1) $display("FAIL pre_reset: busy/dwen got %b/%b expected 1/1", a_busy, a_dwen);
    else n_pass++;
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if ({a_ready, a_busy, a_start, a_error, a_iwen, a_dwen, a_iaddr, a_daddr, a_idata, a_ddata, a_icnt, a_dcnt} !== '0)
      $display("FAIL async_reset: busy/dwen/idata/icnt got %b/%b/%h/%0d expected all 0",
               a_busy, a_dwen, a_idata, a_icnt);
    else n_pass++;
    @(negedge clk); rst = 1'b0;
    ib = ia_q.size();
    @(negedge clk); a_load = 1'b1;
    @(negedge clk); a_load = 1'b0;
    stim_q = {32'hC0DE_0002, MK, MK};
    stream_a(n);
    repeat (3) @(negedge clk);
    n_checks++;
    if (ia_q.size() - ib !== 1 || (ia_q.size() > ib && (ia_q[ib] !== 2'd0 || id_q[ib] !== 32'hC0DE_0002)) || a_start !== 1'b1)
      $display("FAIL restart: writes/start got %0d/%b expected 1 write at 0 and start 1", ia_q.size() - ib, a_start);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_basic_load();
    test_overflow();
    test_marker_first();
    test_gapped();
    test_abort();
    test_random();
    test_async_reset();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
